nb_variable_node: RTL

- Non-binary LDPC variable-node unit that consumes check-to-variable (C2V) messages produced by the check-node array.
- Produces the variable-to-check (V2C) messages that feed the check node's BUF_LLR input on the next iteration.
- Messages are serial: one edge per cycle. It accumulates the channel LLR plus all C2V messages for one symbol, then emits one extrinsic V2C message per edge.
- Optionally produces a hard symbol decision.

---
 rtl/nb_variable_node_if.sv | 36 +++
 rtl/nb_variable_node.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/nb_variable_node_if.sv
// Message bus for the non-binary LDPC variable-node unit.
// Groups the channel-LLR load, C2V input, V2C output and hard-decision signals.
//   master : drives ch_*, c2v_*, v2c_ready; observes everything else (environment side)
//   slave  : the variable node itself
// LLR vectors pack entry f at bits [f*LLR_BIT +: LLR_BIT], two's complement.
interface nb_variable_node_if #(
  parameter int unsigned VAR_DEGREE = 3,
  parameter int unsigned FIELD      = 3,
  parameter int unsigned LLR_BIT    = 3,
  parameter int unsigned SYMBOL_BIT = 2
);
  localparam int unsigned IdxW = (VAR_DEGREE > 1) ? $clog2(VAR_DEGREE) : 1;

  logic                       ch_valid;
  logic [FIELD*LLR_BIT-1:0]   ch_llr;
  logic                       in_ready;
  logic                       c2v_valid;
  logic [FIELD*LLR_BIT-1:0]   c2v_llr;
  logic                       v2c_valid;
  logic                       v2c_ready;
  logic [FIELD*LLR_BIT-1:0]   v2c_llr;
  logic [IdxW-1:0]            v2c_idx;
  logic [SYMBOL_BIT-1:0]      hard_dec;
  logic                       dec_valid;
  logic                       busy;

  modport master (
    output ch_valid, ch_llr, c2v_valid, c2v_llr, v2c_ready,
    input  in_ready, v2c_valid, v2c_llr, v2c_idx, hard_dec, dec_valid, busy
  );

  modport slave (
    input  ch_valid, ch_llr, c2v_valid, c2v_llr, v2c_ready,
    output in_ready, v2c_valid, v2c_llr, v2c_idx, hard_dec, dec_valid, busy
  );
endinterface

// File: rtl/nb_variable_node.sv
// Non-binary LDPC variable-node unit (serial, one edge per cycle).
// Loads the channel LLR, accumulates VAR_DEGREE C2V messages into a running total,
// then emits one extrinsic V2C message per edge: sat(total - c2v[e]), in arrival order.
// Ports:
//   CLK    : clock
//   RST    : synchronous, active-high reset
//   vn_if  : slave modport of nb_variable_node_if
//            ch_valid/ch_llr/in_ready  channel load (accepted in IDLE only)
//            c2v_valid/c2v_llr         C2V messages (consumed in ACCUM only)
//            v2c_valid/v2c_ready/v2c_llr/v2c_idx  extrinsic outputs
//            hard_dec/dec_valid        hard decision pulse
//            busy                      state is not IDLE
// Optional: define NB_VN_HARDDEC_EN to build the hard-decision logic; otherwise
//           hard_dec and dec_valid are tied to zero.
module nb_variable_node #(
  parameter int unsigned VAR_DEGREE = 3,
  parameter int unsigned FIELD      = 3,
  parameter int unsigned LLR_BIT    = 3,
  parameter int unsigned ACC_BIT    = 6,
  parameter int unsigned SYMBOL_BIT = 2
) (
  input logic              CLK,
  input logic              RST,
  nb_variable_node_if.slave vn_if
);
  localparam int unsigned IdxW = (VAR_DEGREE > 1) ? $clog2(VAR_DEGREE) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(VAR_DEGREE - 1);
  // One extra bit so total minus a message can never wrap before clamping.
  localparam logic signed [ACC_BIT:0] SatMax = (ACC_BIT + 1)'(2 ** (LLR_BIT - 1) - 1);
  localparam logic signed [ACC_BIT:0] SatMin = (ACC_BIT + 1)'(-(2 ** (LLR_BIT - 1)));

  typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          cnt_q, cnt_d;
  logic signed [ACC_BIT-1:0] total_q [FIELD];
  logic signed [ACC_BIT-1:0] total_d [FIELD];
  logic signed [LLR_BIT-1:0] edge_buf_q [VAR_DEGREE][FIELD];
  logic signed [LLR_BIT-1:0] edge_buf_d [VAR_DEGREE][FIELD];
  logic [FIELD*LLR_BIT-1:0] v2c_llr_q, v2c_llr_d;

  function automatic logic [LLR_BIT-1:0] sat_diff(input logic signed [ACC_BIT-1:0] tot,
                                                  input logic signed [LLR_BIT-1:0] msg);
    logic signed [ACC_BIT:0] diff;
    diff = (ACC_BIT + 1)'(tot) - (ACC_BIT + 1)'(msg);
    if (diff > SatMax) begin
      diff = SatMax;
    end else if (diff < SatMin) begin
      diff = SatMin;
    end
    return diff[LLR_BIT-1:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    total_d    = total_q;
    edge_buf_d = edge_buf_q;
    v2c_llr_d  = v2c_llr_q;
    unique case (state_q)
      StIdle: begin
        if (vn_if.ch_valid) begin
          for (int f = 0; f < FIELD; f++) begin
            total_d[f] = ACC_BIT'($signed(vn_if.ch_llr[f*LLR_BIT +: LLR_BIT]));
          end
          cnt_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (vn_if.c2v_valid) begin
          for (int f = 0; f < FIELD; f++) begin
            edge_buf_d[cnt_q][f] = $signed(vn_if.c2v_llr[f*LLR_BIT +: LLR_BIT]);
            total_d[f] = total_q[f] +
                         ACC_BIT'($signed(vn_if.c2v_llr[f*LLR_BIT +: LLR_BIT]));
          end
          if (cnt_q == LastIdx) begin
            cnt_d   = '0;
            state_d = StEmit;
            // Edge 0 was buffered earlier (degree >= 2); the total must include this message.
            for (int f = 0; f < FIELD; f++) begin
              v2c_llr_d[f*LLR_BIT +: LLR_BIT] = sat_diff(total_d[f], edge_buf_q[0][f]);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StEmit: begin
        if (vn_if.v2c_ready) begin
          if (cnt_q == LastIdx) begin
            cnt_d     = '0;
            state_d   = StIdle;
            v2c_llr_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            for (int f = 0; f < FIELD; f++) begin
              v2c_llr_d[f*LLR_BIT +: LLR_BIT] = sat_diff(total_q[f], edge_buf_q[cnt_d][f]);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      v2c_llr_q <= '0;
      for (int f = 0; f < FIELD; f++) begin
        total_q[f] <= '0;
      end
      for (int e = 0; e < VAR_DEGREE; e++) begin
        for (int f = 0; f < FIELD; f++) begin
          edge_buf_q[e][f] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      v2c_llr_q  <= v2c_llr_d;
      total_q    <= total_d;
      edge_buf_q <= edge_buf_d;
    end
  end

  assign vn_if.in_ready  = (state_q == StIdle);
  assign vn_if.busy      = (state_q != StIdle);
  assign vn_if.v2c_valid = (state_q == StEmit);
  assign vn_if.v2c_llr   = v2c_llr_q;
  assign vn_if.v2c_idx   = (state_q == StEmit) ? cnt_q : '0;

`ifdef NB_VN_HARDDEC_EN
  logic [SYMBOL_BIT-1:0] hard_dec_q, hard_dec_d;
  logic                  dec_valid_q, dec_valid_d;

  // Strict '>' against a zero floor: all-nonpositive gives symbol 0, ties keep lowest f.
  always_comb begin : p_hard_dec
    logic signed [ACC_BIT-1:0] best;
    best        = '0;
    hard_dec_d  = hard_dec_q;
    dec_valid_d = 1'b0;
    if (state_q == StAccum && state_d == StEmit) begin
      hard_dec_d  = '0;
      dec_valid_d = 1'b1;
      for (int f = 0; f < FIELD; f++) begin
        if (total_d[f] > best) begin
          best       = total_d[f];
          hard_dec_d = SYMBOL_BIT'(f + 1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hard_dec_q  <= '0;
      dec_valid_q <= 1'b0;
    end else begin
      hard_dec_q  <= hard_dec_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  assign vn_if.hard_dec  = hard_dec_q;
  assign vn_if.dec_valid = dec_valid_q;
`else
  assign vn_if.hard_dec  = SYMBOL_BIT'(0);
  assign vn_if.dec_valid = 1'b0;
`endif
endmodule
